// File: rtl/ssd_pkg.sv
// ssd_pkg: shared polarity constants and hex-to-segment table for the seven-segment scanner
package ssd_pkg;
   localparam logic AN_ON  = 1'b0;
   localparam logic AN_OFF = 1'b1;
   localparam logic SEG_ON  = 1'b0;
   localparam logic SEG_OFF = 1'b1;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [0:15][6:0] HEX_SEG = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      return HEX_SEG[h];
   endfunction
endpackage

// File: rtl/ssd_hex_decode.sv
// ssd_hex_decode: nibble to active-low abcdefg segment pattern
module ssd_hex_decode
   import ssd_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] pat
);
   assign pat = hex_to_seg(nib);
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed seven-segment scanner with guard blanking, leading-zero suppression and frame-aligned value commit
// Optional SSD_BLINK_EN adds blink_mask and BLINK_FRAMES for per-digit blinking.
module ssd_scan_ctrl
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int SCAN_DIV_BITS = 18,
   parameter int GUARD_CYCLES  = 64,
   parameter int LZ_SUPPRESS   = 1
`ifdef SSD_BLINK_EN
   ,parameter int BLINK_FRAMES = 32
`endif
) (
   input  logic                    ClkPort,
   input  logic                    Reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    value_load,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SSD_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic [NUM_DIGITS-1:0]   an,
   output logic [7:0]              seg,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
   output logic                    frame_tick
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);
   logic [SCAN_DIV_BITS-1:0] prescaler;
   logic [4*NUM_DIGITS-1:0]  pending;
   logic [4*NUM_DIGITS-1:0]  shadow;
   logic                     pend_valid;
   logic                     tc;
   logic                     last_slot;
   logic                     commit;
   logic [NUM_DIGITS-1:0]    lz_zero;
   logic [NUM_DIGITS-1:0]    an_sel;
   logic [3:0]               nib;
   logic [6:0]               pat;
   logic                     guard;
   logic                     lz_blank;
   logic                     hard_blank;
   logic                     blink_blank;
   logic                     dp_cur;
   logic [NUM_DIGITS-1:0]    an_nxt;
   logic [7:0]               seg_nxt;

   assign tc        = &prescaler;
   assign last_slot = digit_idx == LAST;
   assign commit    = tc && last_slot;

   // scan timebase: free-running prescaler, slot index and end-of-frame pulse
   always_ff @(posedge ClkPort or posedge Reset)
      if (Reset) begin
         prescaler  <= '0;
         digit_idx  <= '0;
         frame_tick <= 1'b0;
      end else begin
         prescaler  <= prescaler + SCAN_DIV_BITS'(1);
         frame_tick <= commit;
         if (tc)
            digit_idx <= last_slot ? '0 : digit_idx + IDX_W'(1);
      end

   // tear-free load: stage into pending, move to shadow only on the last slot's terminal count
   always_ff @(posedge ClkPort or posedge Reset)
      if (Reset) begin
         pending    <= '0;
         pend_valid <= 1'b0;
         shadow     <= '0;
      end else if (commit) begin
         shadow     <= value_load ? value : pend_valid ? pending : shadow;
         pend_valid <= 1'b0;
      end else if (value_load) begin
         pending    <= value;
         pend_valid <= 1'b1;
      end

   // lz_zero[g]: shadow nibbles g..top are all zero; an_sel: one-cold anode for the current slot
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      assign lz_zero[g] = ~|shadow[4*NUM_DIGITS-1:4*g];
      assign an_sel[g]  = (digit_idx == IDX_W'(g)) ? AN_ON : AN_OFF;
   end

   assign nib = shadow[{digit_idx, 2'b00} +: 4];

   ssd_hex_decode u_dec (
      .nib (nib),
      .pat (pat)
   );

`ifdef SSD_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES) + 1;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   // blink timebase: flip phase after every BLINK_FRAMES frame ticks
   always_ff @(posedge ClkPort or posedge Reset)
      if (Reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_tick) begin
         blink_cnt   <= (blink_cnt == BW'(BLINK_FRAMES - 1)) ? '0 : blink_cnt + BW'(1);
         blink_phase <= (blink_cnt == BW'(BLINK_FRAMES - 1)) ? ~blink_phase : blink_phase;
      end

   assign blink_blank = blink_phase && blink_mask[digit_idx];
`else
   assign blink_blank = 1'b0;
`endif

   assign guard      = prescaler < SCAN_DIV_BITS'(GUARD_CYCLES);
   assign lz_blank   = (LZ_SUPPRESS != 0) && (digit_idx != '0) && lz_zero[digit_idx];
   assign hard_blank = guard || !digit_en[digit_idx] || blink_blank;
   assign dp_cur     = dp_mask[digit_idx];

   // next display: a suppressed leading zero keeps its anode only to show a requested Dp
   always_comb begin
      an_nxt  = (hard_blank || (lz_blank && !dp_cur)) ? {NUM_DIGITS{AN_OFF}} : an_sel;
      seg_nxt = hard_blank ? SEG_BLANK : {lz_blank ? {7{SEG_OFF}} : pat, dp_cur ? SEG_ON : SEG_OFF};
   end

   // registered drivers so the pins blank the moment Reset rises
   always_ff @(posedge ClkPort or posedge Reset)
      if (Reset) begin
         an  <= {NUM_DIGITS{AN_OFF}};
         seg <= SEG_BLANK;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
      end
endmodule
